// File: rtl/sd_image_stream_writer_pkg.sv
// sd_image_stream_writer_pkg: shared states, frame geometry and RGB565 pixel layout
package sd_image_stream_writer_pkg;
  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int FRAME_BYTES = 2 * FRAME_PIXELS;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SKIP  = 3'd1,
    PIXEL = 3'd2,
    TAIL  = 3'd3,
    DONE  = 3'd4
  } state_t;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  function automatic rgb565_t pack_pair(input logic [7:0] first, input logic [7:0] second, input logic hi_first);
    return hi_first ? rgb565_t'({first, second}) : rgb565_t'({second, first});
  endfunction
endpackage

// File: rtl/sd_image_stream_writer_if.sv
// sd_image_stream_writer_if: SD byte stream in, frame-buffer write port out
// master = SD controller / frame buffer side, slave = the writer
interface sd_image_stream_writer_if #(parameter int ADDR_W = 17);
  logic [7:0] sd_data;
  logic sd_valid;
  logic sd_read_done;
  logic fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [15:0] fb_data;
  modport master (output sd_data, sd_valid, sd_read_done, input fb_we, fb_addr, fb_data);
  modport slave (input sd_data, sd_valid, sd_read_done, output fb_we, fb_addr, fb_data);
endinterface

// File: rtl/sd_image_stream_writer_rgb565_pair_packer.sv
// rgb565_pair_packer: pairs bytes into RGB565 pixels with a registered write strobe
// ports: clk, reset_n, clr (reset phase), byte_valid/din in; phase, pix_we, pix out
module rgb565_pair_packer
  import sd_image_stream_writer_pkg::*;
#(
  parameter int HI_BYTE_FIRST = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic byte_valid,
  input  logic [7:0] din,
  output logic phase,
  output logic pix_we,
  output rgb565_t pix
);
  logic [7:0] held;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      phase <= 1'b0;
      held <= '0;
      pix_we <= 1'b0;
      pix <= '0;
    end else begin
      pix_we <= byte_valid && phase;
      phase <= !clr && (byte_valid ? !phase : phase);
      if (byte_valid && !phase) held <= din;
      if (byte_valid && phase) pix <= pack_pair(held, din, HI_BYTE_FIRST != 0);
    end
endmodule

// File: rtl/sd_image_stream_writer.sv
// sd_image_stream_writer: SD byte stream to frame-buffer pixel writer
// ports: clk, reset_n, start, abort in; bus (slave) stream/write port;
//        busy, frame_done, err_short, err_timeout, pixel_count out
module sd_image_stream_writer #(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int ADDR_W = 17,
  parameter int HEADER_BYTES = 0,
  parameter int HI_BYTE_FIRST = 1,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  sd_image_stream_writer_if.slave bus,
  output logic busy,
  output logic frame_done,
  output logic err_short,
  output logic err_timeout,
  output logic [ADDR_W-1:0] pixel_count
);
  import sd_image_stream_writer_pkg::*;
  localparam int PIXELS = FRAME_W * FRAME_H;
  localparam int HW = $clog2(HEADER_BYTES + 2);
  state_t state, nxt;
  logic [HW-1:0] hdr_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic active, acc, go, bv, last, to_hit, set_short, set_to, phase, pix_we;
  rgb565_t pix;
  assign active = state inside {SKIP, PIXEL, TAIL};
  assign acc = active && bus.sd_valid;
  assign go = state == IDLE && start && !abort;
  assign bv = state == PIXEL && bus.sd_valid && !abort;
  // the last pixel is recognised when its second byte arrives; its write lands a cycle later
  assign last = acc && state == PIXEL && phase && pixel_count == ADDR_W'(PIXELS - 1);
  assign to_hit = !acc && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  assign bus.fb_we = pix_we;
  assign bus.fb_data = pix;
  assign bus.fb_addr = addr_q;
  rgb565_pair_packer #(.HI_BYTE_FIRST(HI_BYTE_FIRST)) u_pack (
    .clk, .reset_n, .clr(go), .byte_valid(bv), .din(bus.sd_data), .phase, .pix_we, .pix
  );
  always_comb begin
    nxt = state;
    set_short = 1'b0;
    set_to = 1'b0;
    case (state)
      IDLE: if (go) nxt = HEADER_BYTES > 0 ? SKIP : PIXEL;
      SKIP:
        if (bus.sd_read_done) set_short = 1'b1;
        else if (acc && hdr_cnt == HW'(HEADER_BYTES - 1)) nxt = PIXEL;
        else if (to_hit) set_to = 1'b1;
      PIXEL:
        if (last) nxt = bus.sd_read_done ? DONE : TAIL;
        else if (bus.sd_read_done) set_short = 1'b1;
        else if (to_hit) set_to = 1'b1;
      TAIL:
        if (bus.sd_read_done) nxt = DONE;
        else if (to_hit) set_to = 1'b1;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (set_short || set_to) nxt = IDLE;
    if (abort && state != IDLE) begin
      nxt = IDLE;
      set_short = 1'b0;
      set_to = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      hdr_cnt <= '0;
      to_cnt <= '0;
      addr_q <= '0;
      pixel_count <= '0;
      err_short <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= nxt;
      hdr_cnt <= go ? '0 : (acc && state == SKIP) ? hdr_cnt + 1'b1 : hdr_cnt;
      to_cnt <= (acc || nxt != state || !active) ? '0 : to_cnt + 1'b1;
      addr_q <= go ? '0 : (bv && phase) ? pixel_count : addr_q;
      pixel_count <= go ? '0 : pix_we ? pixel_count + 1'b1 : pixel_count;
      err_short <= !go && (err_short || set_short);
      err_timeout <= !go && (err_timeout || set_to);
    end
endmodule

// File: tb/tb_sd_image_stream_writer.sv
// tb_sd_image_stream_writer: scoreboard bench with a pixel-level reference model
module tb_sd_image_stream_writer;
  localparam int FW = 4, FH = 3, P = FW * FH, AW = 5, HB = 3, HBF = 0, TO = 40, TOW = 8;
  logic clk = 0, reset_n = 0, start = 0, abort = 0;
  logic busy, frame_done, err_short, err_timeout;
  logic [AW-1:0] pixel_count;
  int checks = 0, errors = 0, wr_cnt = 0, done_cnt = 0, addr = 0;
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] e;
  sd_image_stream_writer_if #(.ADDR_W(AW)) bus();
  sd_image_stream_writer #(
    .FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW), .HEADER_BYTES(HB),
    .HI_BYTE_FIRST(HBF), .TIMEOUT_CYCLES(TO), .TO_W(TOW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .bus(bus),
    .busy(busy), .frame_done(frame_done), .err_short(err_short),
    .err_timeout(err_timeout), .pixel_count(pixel_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (reset_n) begin
    if (frame_done) done_cnt++;
    if (bus.fb_we) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", bus.fb_addr, bus.fb_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.fb_addr, bus.fb_data} !== e) begin
          errors++;
          $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                   bus.fb_addr, bus.fb_data, e[AW+15:16], e[15:0]);
        end
      end
    end
  end
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    cyc();
    start = 0;
  endtask
  task automatic put(input logic [7:0] b);
    bus.sd_data = b;
    bus.sd_valid = 1;
    cyc();
    bus.sd_valid = 0;
    repeat ($urandom_range(0, 2)) cyc();
  endtask
  task automatic send_pixels(input int n);
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      p = 16'($urandom);
      exp_q.push_back({AW'(addr), p});
      addr++;
      put(p[7:0]);
      put(p[15:8]);
    end
  endtask
  task automatic begin_load();
    pulse_start();
    addr = 0;
    repeat (HB) put(8'hFF);
  endtask
  task automatic read_done();
    bus.sd_read_done = 1;
    cyc();
    bus.sd_read_done = 0;
  endtask
  task automatic run_frame(input int pad, input bit coincide);
    int w0, d0;
    logic [15:0] p;
    w0 = wr_cnt;
    d0 = done_cnt;
    begin_load();
    send_pixels(P / 2);
    pulse_start();
    send_pixels(P / 2 - 1);
    p = 16'($urandom);
    exp_q.push_back({AW'(addr), p});
    addr++;
    put(p[7:0]);
    if (coincide) begin
      bus.sd_data = p[15:8];
      bus.sd_valid = 1;
      bus.sd_read_done = 1;
      cyc();
      bus.sd_valid = 0;
      bus.sd_read_done = 0;
    end else begin
      put(p[15:8]);
      repeat (pad) put(8'($urandom));
      read_done();
    end
    check("frame_done_pulse", frame_done, 1);
    cyc();
    check("frame_done_clear", frame_done, 0);
    check("busy_after_done", busy, 0);
    check("pixel_count_full", pixel_count, P);
    check("err_short_clean", err_short, 0);
    check("err_timeout_clean", err_timeout, 0);
    repeat (2) cyc();
    check("frame_writes", wr_cnt - w0, P);
    check("frame_done_count", done_cnt - d0, 1);
    check("frame_queue_empty", exp_q.size(), 0);
  endtask
  initial begin
    int w0, d0;
    bus.sd_data = 0;
    bus.sd_valid = 0;
    bus.sd_read_done = 0;
    repeat (3) cyc();
    @(negedge clk) reset_n = 1;
    cyc();
    check("reset_busy", busy, 0);
    check("reset_done", frame_done, 0);
    check("reset_err_short", err_short, 0);
    check("reset_err_timeout", err_timeout, 0);
    check("reset_pixel_count", pixel_count, 0);
    check("reset_fb_we", bus.fb_we, 0);
    check("reset_fb_addr", bus.fb_addr, 0);
    check("reset_fb_data", bus.fb_data, 0);
    start = 1;
    abort = 1;
    cyc();
    start = 0;
    abort = 0;
    check("start_abort_idle", busy, 0);
    run_frame(5, 0);
    run_frame(0, 1);
    w0 = wr_cnt;
    d0 = done_cnt;
    begin_load();
    send_pixels(5);
    put(8'hA5);
    read_done();
    check("short_err", err_short, 1);
    check("short_busy", busy, 0);
    repeat (3) cyc();
    check("short_writes", wr_cnt - w0, 5);
    check("short_no_done", done_cnt - d0, 0);
    check("short_queue", exp_q.size(), 0);
    pulse_start();
    check("short_cleared", err_short, 0);
    check("restart_busy", busy, 1);
    abort = 1;
    cyc();
    abort = 0;
    w0 = wr_cnt;
    begin_load();
    send_pixels(2);
    repeat (TO + 5) cyc();
    check("stall_err", err_timeout, 1);
    check("stall_busy", busy, 0);
    repeat (6) put(8'($urandom));
    check("stall_writes", wr_cnt - w0, 2);
    check("stall_queue", exp_q.size(), 0);
    pulse_start();
    check("stall_cleared", err_timeout, 0);
    abort = 1;
    cyc();
    abort = 0;
    w0 = wr_cnt;
    d0 = done_cnt;
    begin_load();
    send_pixels(3);
    put(8'h5A);
    abort = 1;
    cyc();
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_err_short", err_short, 0);
    check("abort_err_timeout", err_timeout, 0);
    repeat (3) cyc();
    check("abort_writes", wr_cnt - w0, 3);
    check("abort_no_done", done_cnt - d0, 0);
    run_frame(3, 0);
    begin_load();
    send_pixels(3);
    #2 reset_n = 0;
    #1;
    check("async_busy", busy, 0);
    check("async_pixel_count", pixel_count, 0);
    check("async_fb_we", bus.fb_we, 0);
    check("async_fb_addr", bus.fb_addr, 0);
    check("async_fb_data", bus.fb_data, 0);
    exp_q.delete();
    @(negedge clk) reset_n = 1;
    cyc();
    run_frame(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
